// File: rtl/id_ex_logic_issue.sv
// Decode-to-execute issue stage for logical ALU ops: builds operands, flags XOR/OR/AND(I),
// and forwards the payload through a 2-entry skid buffer with valid/ready on both sides.
module id_ex_logic_issue #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RD_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] op1,
    output logic [XLEN-1:0] op2,
    output logic [6:0]      opcode,
    output logic [2:0]      func3,
    output logic [RD_W-1:0] rd,
    output logic            logic_op
);

    localparam int unsigned PW = 2 * XLEN + 7 + 3 + RD_W + 1;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    logic [6:0]      dec_opcode;
    logic [2:0]      dec_func3;
    logic [RD_W-1:0] dec_rd;
    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] dec_op2;
    logic            dec_func3_logic;
    logic            dec_logic_op;
    logic [PW-1:0]   in_payload;

    logic            skid_valid;
    logic [PW-1:0]   skid_payload;
    logic [PW-1:0]   main_payload;
    logic            accept;

    always_comb begin
        dec_opcode = instr[6:0];
        dec_func3  = instr[14:12];
        dec_rd     = instr[7 +: RD_W];
        dec_imm    = {{(XLEN - 12){instr[31]}}, instr[31:20]};

        dec_op2 = '0;
        if (dec_opcode == OPC_OP) begin
            dec_op2 = rs2_data;
        end else if (dec_opcode == OPC_OP_IMM) begin
            dec_op2 = dec_imm;
        end

        dec_func3_logic = (dec_func3 == 3'b100) || (dec_func3 == 3'b110) ||
                          (dec_func3 == 3'b111);
        // R-type only counts with funct7 zero; SUB/SRA-style encodings are excluded.
        dec_logic_op = dec_func3_logic &&
                       ((dec_opcode == OPC_OP_IMM) ||
                        ((dec_opcode == OPC_OP) && (instr[31:25] == 7'b0)));

        in_payload = {rs1_data, dec_op2, dec_opcode, dec_func3, dec_rd, dec_logic_op};
    end

    assign in_ready = ~skid_valid;
    assign accept   = in_valid & in_ready;

    assign {op1, op2, opcode, func3, rd, logic_op} = main_payload;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            skid_valid   <= 1'b0;
            main_payload <= '0;
            skid_payload <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || out_ready) begin
            // Accept implies an empty skid, so refill from skid and capture are exclusive.
            if (skid_valid) begin
                main_payload <= skid_payload;
                out_valid    <= 1'b1;
                skid_valid   <= 1'b0;
            end else if (accept) begin
                main_payload <= in_payload;
                out_valid    <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_payload <= in_payload;
            skid_valid   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_logic_issue.sv
// Directed bench for id_ex_logic_issue: decode vectors, backpressure ordering, flush and
// asynchronous reset, each compared against hand-computed values.
module tb_id_ex_logic_issue;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [4:0]  rd;
    logic        logic_op;

    int n_tests;
    int n_fail;

    id_ex_logic_issue #(
        .XLEN(32),
        .RD_W(5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .instr    (instr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .op1      (op1),
        .op2      (op2),
        .opcode   (opcode),
        .func3    (func3),
        .rd       (rd),
        .logic_op (logic_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] XORI_I = {12'hF0F, 5'd1, 3'b100, 5'd3, 7'b0010011};
    localparam logic [31:0] AND_I  = {7'b0000000, 5'd2, 5'd1, 3'b111, 5'd4, 7'b0110011};
    localparam logic [31:0] ANDX_I = {7'b0100000, 5'd2, 5'd1, 3'b111, 5'd6, 7'b0110011};
    localparam logic [31:0] LW_I   = {12'h004, 5'd1, 3'b010, 5'd5, 7'b0000011};
    localparam logic [31:0] OR_I   = {7'b0000000, 5'd2, 5'd1, 3'b110, 5'd7, 7'b0110011};

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        instr     = 32'h0;
        rs1_data  = 32'h0;
        rs2_data  = 32'h0;
        out_ready = 1'b0;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_op1", 64'(op1), 64'd0);
        check("rst_logic_op", 64'(logic_op), 64'd0);
        rst_n = 1'b1;
        step();

        // XORI with negative immediate
        in_valid = 1'b1; instr = XORI_I; rs1_data = 32'h0000_00FF; rs2_data = 32'h1234_5678;
        out_ready = 1'b1;
        step();
        check("xori_valid", 64'(out_valid), 64'd1);
        check("xori_op1", 64'(op1), 64'h0000_00FF);
        check("xori_op2", 64'(op2), 64'hFFFF_FF0F);
        check("xori_opcode", 64'(opcode), 64'h13);
        check("xori_func3", 64'(func3), 64'd4);
        check("xori_rd", 64'(rd), 64'd3);
        check("xori_logic", 64'(logic_op), 64'd1);

        // AND then AND with funct7=0100000, back to back
        instr = AND_I; rs1_data = 32'hF0F0_F0F0; rs2_data = 32'h0FF0_0FF0;
        step();
        check("and_op1", 64'(op1), 64'hF0F0_F0F0);
        check("and_op2", 64'(op2), 64'h0FF0_0FF0);
        check("and_rd", 64'(rd), 64'd4);
        check("and_logic", 64'(logic_op), 64'd1);
        instr = ANDX_I;
        step();
        check("andx_valid", 64'(out_valid), 64'd1);
        check("andx_logic", 64'(logic_op), 64'd0);
        check("andx_op2", 64'(op2), 64'h0FF0_0FF0);

        // Non-logical opcode still passes through
        instr = LW_I; rs1_data = 32'h0000_1000;
        step();
        check("lw_valid", 64'(out_valid), 64'd1);
        check("lw_op2", 64'(op2), 64'd0);
        check("lw_logic", 64'(logic_op), 64'd0);
        check("lw_opcode", 64'(opcode), 64'h03);
        in_valid = 1'b0;
        step();
        check("idle_valid", 64'(out_valid), 64'd0);

        // Backpressure: A -> MAIN, B -> SKID, C held
        out_ready = 1'b0; in_valid = 1'b1; instr = OR_I; rs2_data = 32'h0;
        rs1_data = 32'hAAAA_0001;
        step();
        check("bp_a_valid", 64'(out_valid), 64'd1);
        check("bp_a_ready", 64'(in_ready), 64'd1);
        rs1_data = 32'hBBBB_0002;
        step();
        check("bp_b_ready", 64'(in_ready), 64'd0);
        check("bp_hold_a", 64'(op1), 64'hAAAA_0001);
        rs1_data = 32'hCCCC_0003;
        step();
        check("bp_c_ready", 64'(in_ready), 64'd0);
        check("bp_stable_a", 64'(op1), 64'hAAAA_0001);
        out_ready = 1'b1;
        step();
        check("bp_out_b", 64'(op1), 64'hBBBB_0002);
        check("bp_ready_back", 64'(in_ready), 64'd1);
        step();
        check("bp_out_c", 64'(op1), 64'hCCCC_0003);
        check("bp_c_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        step();
        check("bp_drained", 64'(out_valid), 64'd0);

        // Flush with both entries full and a pending input
        out_ready = 1'b0; in_valid = 1'b1; rs1_data = 32'hD000_0004;
        step();
        rs1_data = 32'hE000_0005;
        step();
        check("fl_full", 64'(in_ready), 64'd0);
        rs1_data = 32'hF000_0006; flush = 1'b1;
        step();
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_ready", 64'(in_ready), 64'd1);
        check("fl_payload_held", 64'(op1), 64'hD000_0004);
        flush = 1'b0; in_valid = 1'b0;
        step();
        check("fl_no_capture", 64'(out_valid), 64'd0);

        // Asynchronous reset between edges
        in_valid = 1'b1; instr = XORI_I; rs1_data = 32'h0000_00FF;
        step();
        in_valid = 1'b0;
        check("ar_pre_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 64'(out_valid), 64'd0);
        check("ar_op1", 64'(op1), 64'd0);
        check("ar_op2", 64'(op2), 64'd0);
        check("ar_opcode", 64'(opcode), 64'd0);
        check("ar_func3", 64'(func3), 64'd0);
        check("ar_rd", 64'(rd), 64'd0);
        check("ar_logic", 64'(logic_op), 64'd0);
        check("ar_ready", 64'(in_ready), 64'd1);
        #1;
        rst_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_logic_issue.md
Name: id_ex_logic_issue

Overview:
Producer side of the execute-stage logical ALU operand interface. It accepts a decoded instruction word plus register-file read data from the decode stage, and builds op2 (rs2 value or sign-extended I-immediate). It then registers op1/op2/opcode/func3/rd toward execute through a 2-entry skid buffer with valid/ready handshakes on both sides. It also flags whether the instruction is a supported logical op (XOR/OR/AND and their immediate forms).

Parameters:
XLEN, 32, datapath width of op1/op2/rs values
RD_W, 5, destination register index width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous pipeline flush (branch/trap), active high
in_valid  input  1  decode stage presents an instruction
in_ready  output  1  this block can accept an instruction
instr  input  32  instruction word
rs1_data  input  XLEN  register file read port 1
rs2_data  input  XLEN  register file read port 2
out_valid  output  1  operands valid toward execute
out_ready  input  1  execute stage accepts operands
op1  output  XLEN  rs1 value
op2  output  XLEN  rs2 value (R-type) or sign-extended imm[11:0] (I-type)
opcode  output  7  instr[6:0]
func3  output  3  instr[14:12]
rd  output  RD_W  instr[11:7]
logic_op  output  1  1 = supported logical op

Behaviour:
- Reset (rst_n low, async): out_valid=0, skid valid=0, in_ready=1, op1/op2=0, opcode=0, func3=0, rd=0, logic_op=0.
- Decode (combinational, on input side):
  - imm = {{20{instr[31]}}, instr[31:20]}.
  - op2_sel = rs2_data when opcode==7'b0110011; imm when opcode==7'b0010011; 0 for any other opcode.
  - logic_op=1 iff func3 is 100, 110 or 111, and either (opcode==0010011) or (opcode==0110011 and instr[31:25]==0). Otherwise 0; the payload is still forwarded.
- Payload = {op1, op2, opcode, func3, rd, logic_op}. Two registers: MAIN drives the outputs; SKID holds overflow.
- in_ready = ~skid_valid. This is a registered term with no combinational path from out_ready.
- Accept = in_valid & in_ready.
- Per-edge rules, in priority order:
  1. flush=1: out_valid<=0, skid_valid<=0. Any same-cycle accepted input is dropped. Payload registers hold their values.
  2. MAIN empty, or out_ready=1:
     - If skid_valid: MAIN<=SKID.
     - Then, on accept: if skid_valid was 1, SKID<=input; else MAIN<=input.
     - out_valid and skid_valid update accordingly.
  3. MAIN full and out_ready=0, on accept: SKID<=input, skid_valid<=1.
- Latency: 1 cycle from accept to out_valid when MAIN is empty or draining.
- Throughput: 1 instruction/cycle under continuous out_ready=1.
- Ordering: strict FIFO. SKID is always older than any new input.
- While out_valid=1 and out_ready=0, all output payloads are stable.
- Full condition: MAIN and SKID both valid -> in_ready=0. It returns to 1 the cycle after the first out_ready handshake.
- Reset asserted mid-transfer: all state is cleared immediately and no handshake completes.

Test Plan:
- XORI: instr with imm=0xF0F, func3=100, opcode=0010011, rd=3; rs1_data=0x0000_00FF; out_ready=1 -> one cycle later out_valid=1, op1=0x0000_00FF, op2=0xFFFF_FF0F, func3=100, rd=3, logic_op=1.
- AND (R-type): funct7=0, func3=111, opcode=0110011; rs1_data=0xF0F0_F0F0, rs2_data=0x0FF0_0FF0 -> op2=0x0FF0_0FF0, logic_op=1. Same with funct7=0100000 -> logic_op=0.
- Backpressure: out_ready=0, three back-to-back in_valid instructions A, B, C:
  - A goes to MAIN, B to SKID; in_ready=0 from the cycle after B, so C is held.
  - Release out_ready -> outputs A, B, C in order with no loss or duplication.
- Flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, and the input is not captured.
- Non-logical opcode (LW, 0000011) -> op2=0, logic_op=0, still handshaked through.
- Async reset asserted between clock edges while out_valid=1 -> out_valid=0 immediately, with all outputs at their reset values.
